aes_out_serializer: RTL and testbench
=====================================

# aes_out_serializer

Output stage directly downstream of the AES round datapath. It captures each finished 128-bit ciphertext block when the datapath pulses `blk_valid`, buffers up to `DEPTH` blocks, and streams them out as 32-bit words over a valid/ready handshake. It decouples the fixed 18-cycle block cadence of the input fetch timing from a consumer that may stall.

## Interface
Parameters:
- `DEPTH`, 2: number of 128-bit block entries buffered (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `blk_valid`  in  1  one-cycle pulse; `blk_data` holds a finished block.
- `blk_data`  in  128  ciphertext block; bits [127:96] form word 0 (first out), bits [31:0] form word 3.
- `blk_ovf`  out  1  one-cycle pulse; a block was dropped because the buffer was full.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  32  current word.
- `out_last`  out  1  high with word 3 of a block.
- `out_parity`  out  4  even parity per byte of `out_data`; bit i covers byte i. Port exists only with `AES_OUT_PARITY_EN`.

## Operation
- Storage: circular buffer of `DEPTH` entries; write pointer, read pointer, occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
- Word index `widx` (2 bits) selects the word of the head entry: 0 → [127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
- Push: `blk_valid` with count < DEPTH writes the entry at the write pointer and advances it.
- Transfer: `out_valid && out_ready`. On transfer `widx` increments. On transfer at `widx`==3, the head entry is popped, the read pointer advances, and `widx` returns to 0.
- Full: `blk_valid` while count==DEPTH and no pop this cycle → block discarded, state unchanged, `blk_ovf` pulses next cycle.
- Push and pop in the same cycle while full: the push is accepted and count stays at DEPTH.
- Push and pop in the same cycle at any other count: both happen and count is unchanged.
- `out_valid` = count > 0.
- `out_data`, `out_last`, and `out_parity` are driven from the head entry and `widx`.
- While `out_valid && !out_ready`, `out_data`, `out_last`, and `out_parity` hold stable.
- `out_valid` never drops without a transfer, except on `rst`.
- No state machine beyond two states: EMPTY when count==0, STREAM otherwise. The state is derived from count, not stored separately.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `blk_ovf`=0, `out_data`=0, `out_parity`=0. Pointers, count, and `widx` are all 0. Buffer contents are don't-care.
- Latency: a block pushed at edge N into an empty buffer gives `out_valid`=1 with word 0 after edge N, i.e. in cycle N+1.
- Throughput: with `out_ready` held high, one word per cycle, so 4 cycles per block. This sustains the 18-cycle input cadence with margin.
- `blk_ovf` is registered: it goes high in the cycle after the dropped `blk_valid`, for exactly one cycle.
- `rst` mid-block discards all buffered blocks and any partially sent block. Streaming resumes at word 0 of the next pushed block.

## Configuration
- `AES_OUT_PARITY_EN` defined:
  - `out_parity` port and its logic are present.
  - Parity is registered alongside `out_data`, so it is valid in the same cycle.
  - Each bit is the XOR of the 8 bits of its byte, giving even parity.
- Not defined: the `out_parity` port is absent, and there is no parity logic or register.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_BLOCK_W`=128, `AES_WORD_W`=32, `AES_WORDS`=4.
  - typedef `aes_block_t` (logic [127:0]) and `aes_word_t` (logic [31:0]).
  - word-index typedef (2 bits).
- One sub-module, `aes_blk_fifo`: DEPTH×128 storage with pointers, count, full/empty, and push/pop. The top level adds word selection, `widx`, handshake, overflow pulse, and parity.

## Test plan
- Reset, then push `blk_data`=0x00112233_44556677_8899AABB_CCDDEEFF with `out_ready`=1 → words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF in cycles N+1..N+4; `out_last` only on the 4th word; then `out_valid`=0.
- `out_ready`=0 for 5 cycles after the push → `out_valid`=1 with `out_data`=0x00112233 stable throughout; raising `out_ready` then delivers the 4 words in order.
- DEPTH=2, `out_ready`=0, push 3 blocks → 3rd block dropped, `blk_ovf`=1 for exactly one cycle; draining yields blocks 1 and 2 only (8 words).
- Full buffer; push coincides with the word-3 transfer of the head → push accepted, no `blk_ovf`, 12 words follow in total.
- Assert `rst` after word 1 of a block → the next cycle has `out_valid`=0 and `out_data`=0; a subsequent push starts at word 0.
- With `AES_OUT_PARITY_EN`: word 0x01030700 → `out_parity`=4'b1010 (bytes 0x01, 0x03, 0x07, 0x00 give odd-weight flags 1, 0, 1, 0 from byte 3 down to byte 0).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES widths, block/word types and word-select helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_WORDS   = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [1:0]             widx_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic aes_word_t aes_word_sel(aes_block_t b, widx_t i);
    return b[(AES_WORDS-1-int'(i))*AES_WORD_W +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Circular buffer of DEPTH ciphertext blocks with head and head+1 read ports.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  aes_block_t                 push_data,
  input  logic                       pop,
  output aes_block_t                 head,
  output aes_block_t                 next_head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  aes_block_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push while full is only accepted if the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  assign head      = mem[rd_ptr_reg];
  assign next_head = mem[rd_ptr_reg + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push_ok) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers finished AES blocks and streams them as 32-bit words (valid/ready).
// Optional per-byte even parity output enabled by AES_OUT_PARITY_EN.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  input  aes_block_t  blk_data,
  output logic        blk_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output aes_word_t   out_data,
  output logic        out_last
`ifdef AES_OUT_PARITY_EN
  ,
  output logic [3:0]  out_parity
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  aes_block_t       head;
  aes_block_t       next_head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             transfer;
  logic             pop;

  widx_t            widx_reg, widx_next;
  aes_word_t        data_reg, data_next;
  logic             last_reg, last_next;
  logic             ovf_reg;

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (blk_valid),
    .push_data (blk_data),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign transfer  = out_valid && out_ready;
  assign pop       = transfer && (widx_reg == 2'd3);

  // Output word is registered, so compute what the head will present next cycle,
  // bypassing the incoming block when it becomes the head immediately.
  always_comb begin
    widx_next = widx_reg;
    data_next = data_reg;
    last_next = last_reg;
    if (empty) begin
      widx_next = 2'd0;
      last_next = 1'b0;
      data_next = blk_valid ? aes_word_sel(blk_data, 2'd0) : '0;
    end else if (pop) begin
      widx_next = 2'd0;
      last_next = 1'b0;
      if (count > CW'(1)) begin
        data_next = aes_word_sel(next_head, 2'd0);
      end else if (blk_valid) begin
        data_next = aes_word_sel(blk_data, 2'd0);
      end else begin
        data_next = '0;
      end
    end else if (transfer) begin
      widx_next = widx_reg + 2'd1;
      data_next = aes_word_sel(head, widx_reg + 2'd1);
      last_next = (widx_reg == 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_reg <= '0;
      data_reg <= '0;
      last_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      widx_reg <= widx_next;
      data_reg <= data_next;
      last_reg <= last_next;
      ovf_reg  <= blk_valid && full && !pop;
    end
  end

  assign out_data = data_reg;
  assign out_last = last_reg;
  assign blk_ovf  = ovf_reg;

`ifdef AES_OUT_PARITY_EN
  logic [3:0] parity_next;
  logic [3:0] parity_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_parity
    assign parity_next[gi] = ^data_next[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= '0;
    end else begin
      parity_reg <= parity_next;
    end
  end

  assign out_parity = parity_reg;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Bench for aes_out_serializer: queue-based reference model plus directed literal checks.
module tb_aes_out_serializer;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_ovf;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
`ifdef AES_OUT_PARITY_EN
  logic [3:0]   out_parity;
`endif

  int total = 0;
  int bad   = 0;

  aes_out_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ovf   (blk_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef AES_OUT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [127:0] q[$];
  int           m_widx  = 0;
  logic         m_ovf   = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    bit xfer, popm;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_widx = 0;
      m_ovf  = 1'b0;
    end else begin
      xfer  = (q.size() > 0) && out_ready;
      popm  = xfer && (m_widx == 3);
      m_ovf = blk_valid && (q.size() == DEPTH) && !popm;
      if (xfer) begin
        if (m_widx == 3) begin
          void'(q.pop_front());
          m_widx = 0;
        end else begin
          m_widx++;
        end
      end
      if (blk_valid && !m_ovf) q.push_back(blk_data);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    if (started) begin
      e_valid = (q.size() > 0);
      e_data  = e_valid ? 32'(q[0] >> (96 - 32*m_widx)) : 32'd0;
      e_last  = e_valid && (m_widx == 3);
      chk("model_valid", 128'(out_valid), 128'(e_valid));
      chk("model_data",  128'(out_data),  128'(e_data));
      chk("model_last",  128'(out_last),  128'(e_last));
      chk("model_ovf",   128'(blk_ovf),   128'(m_ovf));
`ifdef AES_OUT_PARITY_EN
      begin
        logic [3:0] e_par;
        for (int b = 0; b < 4; b++) e_par[b] = ^e_data[b*8 +: 8];
        chk("model_parity", 128'(out_parity), 128'(e_par));
      end
`endif
      if (out_valid && out_ready)
        $display("xfer t=%0t data=%h last=%b ovf=%b", $time, out_data, out_last, blk_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] b, input int k);
    return 32'(b >> (96 - 32*k));
  endfunction

  task automatic push(input logic [127:0] d);
    blk_valid = 1'b1;
    blk_data  = d;
    cyc();
    blk_valid = 1'b0;
  endtask

  // Expects the head word k of block b to be presented now and transferred.
  task automatic drain_block(input string name, input logic [127:0] b);
    for (int k = 0; k < 4; k++) begin
      chk({name, "_valid"}, 128'(out_valid), 128'(1'b1));
      chk({name, "_word"},  128'(out_data),  128'(wsel(b, k)));
      chk({name, "_last"},  128'(out_last),  128'(k == 3));
      cyc();
    end
  endtask

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] BLK_3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  initial begin
    logic [31:0] w0;
    repeat (3) cyc();
    chk("reset_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_data",  128'(out_data),  128'(32'd0));
    chk("reset_last",  128'(out_last),  128'(1'b0));
    chk("reset_ovf",   128'(blk_ovf),   128'(1'b0));
    rst = 1'b0;
    cyc();

    // Basic streaming, literal words.
    out_ready = 1'b1;
    push(BLK_A);
    chk("t1_w0", 128'(out_data), 128'(32'h00112233));
    cyc();
    chk("t1_w1", 128'(out_data), 128'(32'h44556677));
    cyc();
    chk("t1_w2", 128'(out_data), 128'(32'h8899AABB));
    chk("t1_last_early", 128'(out_last), 128'(1'b0));
    cyc();
    chk("t1_w3", 128'(out_data), 128'(32'hCCDDEEFF));
    chk("t1_last", 128'(out_last), 128'(1'b1));
    cyc();
    chk("t1_idle_valid", 128'(out_valid), 128'(1'b0));

    // Stall holds word 0 stable.
    out_ready = 1'b0;
    push(BLK_A);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 128'(out_valid), 128'(1'b1));
      chk("t2_hold_data",  128'(out_data),  128'(32'h00112233));
      cyc();
    end
    out_ready = 1'b1;
    drain_block("t2", BLK_A);
    chk("t2_idle", 128'(out_valid), 128'(1'b0));

    // Overflow: third block dropped.
    out_ready = 1'b0;
    push(BLK_1);
    push(BLK_2);
    chk("t3_no_ovf", 128'(blk_ovf), 128'(1'b0));
    push(BLK_3);
    chk("t3_ovf_pulse", 128'(blk_ovf), 128'(1'b1));
    cyc();
    chk("t3_ovf_clear", 128'(blk_ovf), 128'(1'b0));
    out_ready = 1'b1;
    drain_block("t3b1", BLK_1);
    drain_block("t3b2", BLK_2);
    chk("t3_idle", 128'(out_valid), 128'(1'b0));

    // Push coincides with the word-3 pop of a full buffer.
    out_ready = 1'b0;
    push(BLK_1);
    push(BLK_2);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_w", 128'(out_data), 128'(wsel(BLK_1, k)));
      cyc();
    end
    chk("t4_w3", 128'(out_data), 128'(wsel(BLK_1, 3)));
    push(BLK_3);
    chk("t4_no_ovf", 128'(blk_ovf), 128'(1'b0));
    drain_block("t4b2", BLK_2);
    drain_block("t4b3", BLK_3);
    chk("t4_idle", 128'(out_valid), 128'(1'b0));

    // Reset mid-block.
    push(BLK_A);
    cyc();
    chk("t5_w1", 128'(out_data), 128'(32'h44556677));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_valid", 128'(out_valid), 128'(1'b0));
    chk("t5_rst_data",  128'(out_data),  128'(32'd0));
    push(BLK_2);
    chk("t5_restart", 128'(out_data), 128'(32'hA0A1A2A3));
    cyc(); cyc(); cyc(); cyc();

`ifdef AES_OUT_PARITY_EN
    out_ready = 1'b0;
    push(128'h01030700_00000000_00000000_00000000);
    chk("t6_parity", 128'(out_parity), 128'(4'b1010));
    out_ready = 1'b1;
    repeat (5) cyc();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      blk_valid = ($urandom_range(0, 3) == 0);
      blk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = ($urandom_range(0, 2) != 0);
      if (i % 700 == 699) out_ready = 1'b0;
      cyc();
    end
    blk_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) cyc();
    w0 = out_data;
    chk("final_idle_data", 128'(w0), 128'(32'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
